// File: rtl/vr16_dmem_responder.sv
// vr16_dmem_responder: single-port 16-bit data RAM answering a req/ready
// handshake after WAIT_CYCLES wait states.
//
// Ports:
//   global_clk   : clock. All state changes on its rising edge.
//   global_reset : asynchronous reset, active low.
//   req          : request. we/addr/wdata are captured on the accept edge.
//   we           : 1 = write, 0 = read.
//   addr         : 16-bit word address. Only addr < 2**ADDR_WIDTH is in range.
//   wdata        : write data.
//   ready        : one-cycle completion strobe.
//   rdata        : read data. Zero unless ready is high on an in-range read.
//   err          : out-of-range flag. Only meaningful while ready is high.
//   busy         : high from the accept edge through the ready cycle.
//   txn_count    : completed transactions, wrapping at 16 bits.
//
// Timing: the RAM is accessed on the edge that enters RESP. The registered
// response is loaded on the edge that leaves RESP, so ready is high in the
// cycle that starts WAIT_CYCLES+1 edges after the accept edge. The FSM sits
// in IDLE during that cycle, which lets a held req be accepted straight away.
module vr16_dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        global_clk,
    input  logic        global_reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [15:0] txn_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  wcnt, wcnt_nx;

    logic        we_q;
    logic [15:0] addr_q, wdata_q;

    logic [15:0] mem [DEPTH];
    logic [15:0] rd_q;

    logic        src_we, src_ok, q_ok, enter_resp, ram_we;
    logic [15:0] src_addr, src_wdata;

    logic        ready_d, err_d, busy_d;
    logic [15:0] rdata_d;

    // With WAIT_CYCLES=0, RESP is entered on the accept edge itself, before
    // the capture registers hold the request. So the RAM takes the live
    // inputs while in IDLE and the captured copy otherwise.
    assign src_we    = (state == IDLE) ? we    : we_q;
    assign src_addr  = (state == IDLE) ? addr  : addr_q;
    assign src_wdata = (state == IDLE) ? wdata : wdata_q;

    // Range test on the full 16-bit address. Truncating to the index width
    // would alias out-of-range writes onto low words.
    assign src_ok = (src_addr >> ADDR_WIDTH) == 16'd0;
    assign q_ok   = (addr_q >> ADDR_WIDTH) == 16'd0;

    assign enter_resp = (state != RESP) && (state_nx == RESP);

    // Reset holds the FSM in IDLE, but a held req with WAIT_CYCLES=0 would
    // still look like a RESP entry. The reset term blocks that stray write.
    assign ram_we = enter_resp && src_we && src_ok && global_reset;

    // State register
    always_ff @(posedge global_clk or negedge global_reset) begin
        if (!global_reset) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Request capture on the accept edge. Later input changes are ignored.
    always_ff @(posedge global_clk or negedge global_reset) begin
        if (!global_reset) begin
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
        end else if (state == IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Next-state logic. wcnt holds the number of WAIT cycles still to run.
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: begin
                if (req) begin
                    wcnt_nx  = 4'(WAIT_CYCLES);
                    state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wcnt <= 4'd1) begin
                    wcnt_nx  = 4'd0;
                    state_nx = RESP;
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: begin
                state_nx = IDLE;
                wcnt_nx  = 4'd0;
            end
        endcase
    end

    // Output logic, evaluated one cycle ahead of the output registers.
    always_comb begin
        ready_d = (state == RESP);
        err_d   = (state == RESP) && !q_ok;
        rdata_d = ((state == RESP) && !we_q && q_ok) ? rd_q : 16'd0;
        busy_d  = (state_nx != IDLE) || (state == RESP);
    end

    always_ff @(posedge global_clk or negedge global_reset) begin
        if (!global_reset) begin
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= 16'd0;
            busy      <= 1'b0;
            txn_count <= 16'd0;
        end else begin
            ready <= ready_d;
            err   <= err_d;
            rdata <= rdata_d;
            busy  <= busy_d;
            if (state == RESP)
                txn_count <= txn_count + 16'd1;
        end
    end

    // RAM. Reset does not clear it. rd_q gets the word as it was before any
    // write on the same edge.
    always_ff @(posedge global_clk) begin
        if (ram_we)
            mem[src_addr[ADDR_WIDTH-1:0]] <= src_wdata;
        if (enter_resp)
            rd_q <= mem[src_addr[ADDR_WIDTH-1:0]];
    end

endmodule

// File: tb/tb_vr16_dmem_responder.sv
// Bench for vr16_dmem_responder.
// dut0: ADDR_WIDTH=8, WAIT_CYCLES=2. Directed table, reset abort, random traffic
//       checked against an array model, and the counter wrap.
// dut1: ADDR_WIDTH=8, WAIT_CYCLES=0. Back-to-back burst with req held high.
module tb_vr16_dmem_responder;
    localparam int W0 = 2;

    logic        clk, rst_n;
    logic        req0, we0, ready0, err0, busy0;
    logic [15:0] addr0, wdata0, rdata0, cnt0;
    logic        req1, we1, ready1, err1, busy1;
    logic [15:0] addr1, wdata1, rdata1, cnt1;

    vr16_dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(W0)) dut0 (
        .global_clk(clk), .global_reset(rst_n), .req(req0), .we(we0),
        .addr(addr0), .wdata(wdata0), .ready(ready0), .rdata(rdata0),
        .err(err0), .busy(busy0), .txn_count(cnt0));

    vr16_dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut1 (
        .global_clk(clk), .global_reset(rst_n), .req(req1), .we(we1),
        .addr(addr1), .wdata(wdata1), .ready(ready1), .rdata(rdata1),
        .err(err1), .busy(busy1), .txn_count(cnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        bit          exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        tbl[12];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] mem_m [256];
    bit          known [256];
    logic [15:0] cnt_m;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // One transaction on dut0. After the accept edge the inputs are
    // scrambled so that only the captured request can produce the result.
    task automatic txn0(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input bit exp_e,
                        input logic [15:0] exp_c, input bit chk_rd, input string tag);
        int edges;
        bit seen;
        @(negedge clk);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        @(posedge clk); #1;
        req0 = 1'b0; we0 = ~w; addr0 = ~a; wdata0 = ~d;
        chk({tag, " busy at accept"}, 16'(busy0), 16'd1);
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (ready0) seen = 1'b1;
        end
        chk({tag, " latency"}, 16'(edges), 16'(W0 + 1));
        if (seen) begin
            chk({tag, " err"}, 16'(err0), 16'(exp_e));
            if (chk_rd) chk({tag, " rdata"}, rdata0, exp_rd);
            chk({tag, " count"}, cnt0, exp_c);
            chk({tag, " busy in ready"}, 16'(busy0), 16'd1);
        end
        @(posedge clk); #1;
        chk({tag, " ready strobe"}, 16'(ready0), 16'd0);
        chk({tag, " busy after"}, 16'(busy0), 16'd0);
        chk({tag, " rdata idle"}, rdata0, 16'd0);
    endtask

    initial begin
        bit          w, e, k_rd;
        logic [15:0] a, d, xr;
        int          idx;

        tbl[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 16'd1};
        tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 16'd2};
        tbl[2]  = '{1'b1, 16'h0000, 16'h5A5A, 16'h0000, 1'b0, 16'd3};
        tbl[3]  = '{1'b1, 16'h0100, 16'hDEAD, 16'h0000, 1'b1, 16'd4};
        tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0, 16'd5};
        tbl[5]  = '{1'b1, 16'hFFFF, 16'h7777, 16'h0000, 1'b1, 16'd6};
        tbl[6]  = '{1'b1, 16'h00FF, 16'h1111, 16'h0000, 1'b0, 16'd7};
        tbl[7]  = '{1'b0, 16'h00FF, 16'h0000, 16'h1111, 1'b0, 16'd8};
        tbl[8]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 16'd9};
        tbl[9]  = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1, 16'd10};
        tbl[10] = '{1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b0, 16'd11};
        tbl[11] = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0, 16'd12};
        for (int i = 0; i < 256; i++) known[i] = 1'b0;

        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset ready", 16'(ready0), 16'd0);
        chk("reset busy", 16'(busy0), 16'd0);
        chk("reset err", 16'(err0), 16'd0);
        chk("reset rdata", rdata0, 16'd0);
        chk("reset count", cnt0, 16'd0);
        chk("reset count1", cnt1, 16'd0);
        #3 rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            txn0(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err,
                 tbl[i].exp_cnt, 1'b1, $sformatf("vec%0d", i));
            if (tbl[i].we && !tbl[i].exp_err) begin
                mem_m[tbl[i].addr[7:0]] = tbl[i].wdata;
                known[tbl[i].addr[7:0]] = 1'b1;
            end
        end

        // Reset asserted in WAIT must drop the write of 0x1234 and not count it.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1234;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort ready", 16'(ready0), 16'd0);
        chk("abort busy", 16'(busy0), 16'd0);
        chk("abort err", 16'(err0), 16'd0);
        chk("abort rdata", rdata0, 16'd0);
        chk("abort count", cnt0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_m = 16'd1;
        txn0(1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, cnt_m, 1'b1, "after abort");

        // Random traffic against the array model
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            d = 16'($urandom);
            e = (a >= 16'd256);
            idx = int'(a[7:0]);
            k_rd = w || e || known[idx];
            xr = (!w && !e && known[idx]) ? mem_m[idx] : 16'h0000;
            cnt_m = cnt_m + 16'd1;
            txn0(w, a, d, xr, e, cnt_m, k_rd, $sformatf("rnd%0d", i));
            if (w && !e) begin
                mem_m[idx] = d;
                known[idx] = 1'b1;
            end
        end

        // Counter wrap: preset to 0xFFFF, then complete two more transactions.
        @(negedge clk);
        force dut0.txn_count = 16'hFFFF;
        #1 release dut0.txn_count;
        #1 chk("count preset", cnt0, 16'hFFFF);
        txn0(1'b0, 16'h0010, 16'h0000, mem_m[16], 1'b0, 16'h0000, known[16], "wrap");
        txn0(1'b1, 16'h0300, 16'h4444, 16'h0000, 1'b1, 16'h0001, 1'b1, "post wrap");

        // dut1: req held through three writes, one ready every two cycles
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0001; wdata1 = 16'hA001;
        begin
            logic [15:0] c1;
            bit          er;
            c1 = 16'd0;
            for (int k = 0; k < 7; k++) begin
                @(posedge clk); #1;
                er = (k % 2 == 1) && (k <= 5);
                chk($sformatf("burst ready k%0d", k), 16'(ready1), 16'(er));
                chk($sformatf("burst busy k%0d", k), 16'(busy1), 16'(k <= 5));
                if (er) begin
                    c1 = c1 + 16'd1;
                    chk($sformatf("burst count k%0d", k), cnt1, c1);
                    chk($sformatf("burst err k%0d", k), 16'(err1), 16'd0);
                    if (k == 5) req1 = 1'b0;
                    else begin
                        addr1  = addr1 + 16'd1;
                        wdata1 = wdata1 + 16'd1;
                    end
                end
            end
        end
        chk("burst final count", cnt1, 16'd3);

        // dut1 read-back with a one-edge latency
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
        @(posedge clk); #1;
        req1 = 1'b0;
        chk("w0 read early", 16'(ready1), 16'd0);
        @(posedge clk); #1;
        chk("w0 read ready", 16'(ready1), 16'd1);
        chk("w0 read rdata", rdata1, 16'hA002);
        chk("w0 read count", cnt1, 16'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
